dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is a debug/DMA master.
- Accepts at most one request per cycle and registers it into a command stage. The command stage drives the data memory for one cycle, then a registered response returns to the owning port.
- Detects misaligned or illegal accesses and answers them with an error, without touching memory.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/arb2_rr.sv | 46 ++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// requester ids, the command-stage record and the alignment check.
package dmem_pkg;

  localparam logic [1:0] RW_B       = 2'b00;
  localparam logic [1:0] RW_H       = 2'b01;
  localparam logic [1:0] RW_W       = 2'b10;
  localparam logic [1:0] RW_ILL     = 2'b11;
  localparam int         RW_UNS_BIT = 2;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  rw_type;
    logic [31:0] wdata;
    logic        err;
  } cmd_t;

  // Also flags the reserved size encoding, so one call covers every error case.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] rw_type);
    logic bad;
    bad = 1'b0;
    case (rw_type[1:0])
      RW_H:    bad = addr_lo[0];
      RW_W:    bad = (addr_lo != 2'b00);
      RW_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for both arbiter ports. The arbiter uses the slave
// modport; requesters (or a bench) use master.
//
// Handshake: pN_req is valid and its payload stays stable until pN_gnt is
// seen high in the same cycle; the transfer happens on that rising edge.
// pN_rsp_valid is a single-cycle pulse with no back-pressure.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [2:0]  p0_rw_type;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rsp_valid;
  logic        p0_rsp_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [2:0]  p1_rw_type;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rsp_valid;
  logic        p1_rsp_err;
  logic [31:0] p1_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_rw_type, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_rw_type, p1_wdata,
    output p0_gnt, p0_rsp_valid, p0_rsp_err, p0_rdata,
    output p1_gnt, p1_rsp_valid, p1_rsp_err, p1_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_rw_type, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_rw_type, p1_wdata,
    input  p0_gnt, p0_rsp_valid, p0_rsp_err, p0_rdata,
    input  p1_gnt, p1_rsp_valid, p1_rsp_err, p1_rdata
  );
endinterface

// File: rtl/arb2_rr.sv
// Two-way arbiter: round-robin (PRIO_MODE=0) or port-0 priority with a
// starvation guard for port 1 (PRIO_MODE=1). One-hot grant, combinational.
module arb2_rr #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam int             WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]  WAIT_MAX = WW'(MAX_WAIT);

  logic          last_grant_q, last_grant_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    gnt_o        = req_i;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;

    if (req_i == 2'b11) begin
      if (PRIO_MODE == 0) gnt_o = last_grant_q ? 2'b01 : 2'b10;
      else                gnt_o = (wait_cnt_q == WAIT_MAX) ? 2'b10 : 2'b01;
    end

    if (gnt_o != 2'b00) last_grant_d = gnt_o[1];

    // Refusal counter saturates so a long-blocked port 1 stays at the forcing value.
    if (gnt_o[1])                             wait_cnt_d = '0;
    else if (req_i[1] && wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core LSU (port 0) and a
// debug/DMA master (port 1): accept -> one-cycle memory command -> response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_arbiter_if.slave ports,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_rw_type,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  req, gnt;
  cmd_t        cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        mem_active;
  logic        hit0, hit1;
  logic [31:0] load_data;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  assign req = {ports.p1_req, ports.p0_req};

  arb2_rr #(.PRIO_MODE(PRIO_MODE), .MAX_WAIT(MAX_WAIT)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign ports.p0_gnt = gnt[0];
  assign ports.p1_gnt = gnt[1];

  // The command stage empties every cycle, so acceptance never has to stall.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = |gnt;
    if (gnt[1]) begin
      cmd_d.port    = PORT_DBG;
      cmd_d.we      = ports.p1_we;
      cmd_d.addr    = ports.p1_addr;
      cmd_d.rw_type = ports.p1_rw_type;
      cmd_d.wdata   = ports.p1_wdata;
    end else if (gnt[0]) begin
      cmd_d.port    = PORT_CORE;
      cmd_d.we      = ports.p0_we;
      cmd_d.addr    = ports.p0_addr;
      cmd_d.rw_type = ports.p0_rw_type;
      cmd_d.wdata   = ports.p0_wdata;
    end
    cmd_d.err = misaligned(cmd_d.addr[1:0], cmd_d.rw_type);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign mem_active  = cmd_valid_q && !cmd_q.err;
  assign mem_we      = mem_active &&  cmd_q.we;
  assign mem_re      = mem_active && !cmd_q.we;
  assign mem_addr    = mem_active ? cmd_q.addr    : '0;
  assign mem_rw_type = mem_active ? cmd_q.rw_type : '0;
  assign mem_wdata   = mem_active ? cmd_q.wdata   : '0;

  // Load data is taken from memory at the end of the access cycle; stores and errors return zero.
  always_comb begin
    hit0        = cmd_valid_q && (cmd_q.port == PORT_CORE);
    hit1        = cmd_valid_q && (cmd_q.port == PORT_DBG);
    load_data   = (!cmd_q.we && !cmd_q.err) ? mem_rdata : '0;
    rsp_valid_d = {hit1, hit0};
    rsp_err_d   = {hit1 && cmd_q.err, hit0 && cmd_q.err};
    rdata0_d    = hit0 ? load_data : '0;
    rdata1_d    = hit1 ? load_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ports.p0_rsp_valid = rsp_valid_q[0];
  assign ports.p1_rsp_valid = rsp_valid_q[1];
  assign ports.p0_rsp_err   = rsp_err_q[0];
  assign ports.p1_rsp_err   = rsp_err_q[1];
  assign ports.p0_rdata     = rdata0_q;
  assign ports.p1_rdata     = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance with a byte-level reference
// memory and response scoreboard, plus a fixed-priority instance for grant checks.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MAX_WAIT = 8;
  localparam int W        = 66;  // {port, err, rdata[31:0], due_cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  dmem_arbiter_if ifa ();
  dmem_arbiter_if ifb ();

  logic        a_mem_we, a_mem_re, b_mem_we, b_mem_re;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, b_mem_addr, b_mem_wdata;
  logic [2:0]  a_mem_rw_type, b_mem_rw_type;

  dmem_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAX_WAIT)) dut_a (
    .clk(clk), .rst_n(rst_n), .ports(ifa),
    .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_addr(a_mem_addr),
    .mem_rw_type(a_mem_rw_type), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAX_WAIT)) dut_b (
    .clk(clk), .rst_n(rst_n), .ports(ifb),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_addr(b_mem_addr),
    .mem_rw_type(b_mem_rw_type), .mem_wdata(b_mem_wdata), .mem_rdata(32'h0)
  );

  // ---------------- memory attached to dut_a (16 words at 0x100) ----------------
  logic [31:0] mem_w [0:15] = '{default: 32'h0};
  logic [31:0] mw_word, mw_sh, mw_mask, mw_val;

  always_comb begin
    mw_word = mem_w[a_mem_addr[5:2]];
    mw_sh   = mw_word >> (8 * a_mem_addr[1:0]);
    case (a_mem_rw_type[1:0])
      2'b00:   a_mem_rdata = a_mem_rw_type[2] ? {24'h0, mw_sh[7:0]}  : {{24{mw_sh[7]}}, mw_sh[7:0]};
      2'b01:   a_mem_rdata = a_mem_rw_type[2] ? {16'h0, mw_sh[15:0]} : {{16{mw_sh[15]}}, mw_sh[15:0]};
      default: a_mem_rdata = mw_word;
    endcase
    case (a_mem_rw_type[1:0])
      2'b00:   mw_mask = 32'h0000_00FF << (8 * a_mem_addr[1:0]);
      2'b01:   mw_mask = 32'h0000_FFFF << (8 * a_mem_addr[1:0]);
      default: mw_mask = 32'hFFFF_FFFF;
    endcase
    mw_val = a_mem_wdata << (8 * a_mem_addr[1:0]);
  end

  always @(posedge clk)
    if (a_mem_we) mem_w[a_mem_addr[5:2]] <= (mem_w[a_mem_addr[5:2]] & ~mw_mask) | (mw_val & mw_mask);

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  logic [7:0] ref_b [0:63] = '{default: 8'h0};

  function automatic logic [31:0] ref_access(input logic we, input logic [31:0] addr,
                                             input logic [2:0] rw, input logic [31:0] wd,
                                             output logic err);
    int n, o;
    logic [31:0] v;
    n   = (rw[1:0] == 2'b00) ? 1 : (rw[1:0] == 2'b01) ? 2 : 4;
    o   = int'(addr[5:0]);
    err = (rw[1:0] == 2'b11) || (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    v   = 32'h0;
    if (err) return 32'h0;
    if (we) begin
      for (int i = 0; i < n; i++) ref_b[o + i] = wd[8*i +: 8];
      return 32'h0;
    end
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[o + i];
    if (!rw[2] && n < 4 && v[8*n-1])
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- stimulus state ----------------
  logic        pa [0:1];
  logic        wea [0:1];
  logic [31:0] addra [0:1];
  logic [31:0] wda [0:1];
  logic [2:0]  rwa [0:1];
  logic        pb [0:1];
  logic        gseen_a [0:1];
  logic        gseen_b [0:1];
  bit          rand_a = 1'b0;
  bit          bcont  = 1'b0;
  int          b_prob = 0;
  logic        bseq[$];

  task automatic drive();
    ifa.p0_req = pa[0]; ifa.p0_we = wea[0]; ifa.p0_addr = addra[0];
    ifa.p0_rw_type = rwa[0]; ifa.p0_wdata = wda[0];
    ifa.p1_req = pa[1]; ifa.p1_we = wea[1]; ifa.p1_addr = addra[1];
    ifa.p1_rw_type = rwa[1]; ifa.p1_wdata = wda[1];
    ifb.p0_req = pb[0]; ifb.p1_req = pb[1];
  endtask

  task automatic rand_req(input int p);
    pa[p]    = 1'b1;
    wea[p]   = 1'($urandom_range(1));
    rwa[p]   = 3'($urandom_range(7));
    addra[p] = 32'h100 + 32'($urandom_range(63));
    wda[p]   = $urandom;
    if ($urandom_range(3) != 0) begin
      if (rwa[p][1:0] == 2'b01)      addra[p][0]   = 1'b0;
      else if (rwa[p][1:0] == 2'b10) addra[p][1:0] = 2'b00;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (gseen_a[p]) pa[p] = 1'b0;
      if (gseen_b[p]) pb[p] = 1'b0;
      gseen_a[p] = 1'b0;
      gseen_b[p] = 1'b0;
      if (!pb[p] && $urandom_range(99) < b_prob) pb[p] = 1'b1;
      if (rand_a && !pa[p] && $urandom_range(99) < 60) rand_req(p);
    end
    drive();
  endtask

  // Returns just after the falling edge of the cycle in which the request was accepted.
  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [2:0] rw, input logic [31:0] wd);
    next_cycle();
    pa[p] = 1'b1; wea[p] = we; addra[p] = addr; rwa[p] = rw; wda[p] = wd;
    drive();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (gseen_a[p]) return;
      next_cycle();
    end
    chk("issue_timeout", 32'(gseen_a[p]), 32'd1);
  endtask

  // ---------------- scoreboard for dut_a ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] head;
  logic         a_last = 1'b1;
  logic         ae0, ae1, hv, ev, e_err;
  logic         acc_p, acc_we;
  logic [31:0]  acc_addr, acc_wd, e_rdata;
  logic [2:0]   acc_rw;
  logic         prev_v = 1'b0, prev_we, prev_err;
  logic [31:0]  prev_addr, prev_wd;
  logic [2:0]   prev_rw;
  logic [1:0]   obs_v, obs_e;
  logic [31:0]  obs_d [0:1];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      a_last = 1'b1;
      prev_v = 1'b0;
    end else begin
      ae1 = ifa.p1_req && (!ifa.p0_req || !a_last);
      ae0 = ifa.p0_req && !ae1;
      chk("a_gnt0", 32'(ifa.p0_gnt), 32'(ae0));
      chk("a_gnt1", 32'(ifa.p1_gnt), 32'(ae1));
      if (ae0 || ae1) a_last = ae1;

      chk("a_mem_we", 32'(a_mem_we), 32'(prev_v && prev_we && !prev_err));
      chk("a_mem_re", 32'(a_mem_re), 32'(prev_v && !prev_we && !prev_err));
      if (prev_v && !prev_err) begin
        chk("a_mem_addr", a_mem_addr, prev_addr);
        chk("a_mem_rw", 32'(a_mem_rw_type), 32'(prev_rw));
        if (prev_we) chk("a_mem_wdata", a_mem_wdata, prev_wd);
      end else begin
        chk("a_mem_addr_idle", a_mem_addr, 32'h0);
      end

      hv = 1'b0;
      head = '0;
      if (exp_q.size() > 0 && exp_q[0][31:0] == 32'(cyc)) begin
        hv = 1'b1;
        head = exp_q.pop_front();
      end
      obs_v = {ifa.p1_rsp_valid, ifa.p0_rsp_valid};
      obs_e = {ifa.p1_rsp_err, ifa.p0_rsp_err};
      obs_d[0] = ifa.p0_rdata;
      obs_d[1] = ifa.p1_rdata;
      for (int p = 0; p < 2; p++) begin
        ev = hv && (head[65] == p[0]);
        chk($sformatf("a_rsp_valid%0d", p), 32'(obs_v[p]), 32'(ev));
        if (ev) begin
          chk($sformatf("a_rsp_err%0d", p), 32'(obs_e[p]), 32'(head[64]));
          chk($sformatf("a_rdata%0d", p), obs_d[p], head[63:32]);
        end
      end

      prev_v = 1'b0;
      if (ifa.p0_gnt || ifa.p1_gnt) begin
        acc_p    = ifa.p1_gnt;
        acc_we   = acc_p ? ifa.p1_we      : ifa.p0_we;
        acc_addr = acc_p ? ifa.p1_addr    : ifa.p0_addr;
        acc_rw   = acc_p ? ifa.p1_rw_type : ifa.p0_rw_type;
        acc_wd   = acc_p ? ifa.p1_wdata   : ifa.p0_wdata;
        e_rdata  = ref_access(acc_we, acc_addr, acc_rw, acc_wd, e_err);
        exp_q.push_back({acc_p, e_err, e_rdata, 32'(cyc + 2)});
        prev_v = 1'b1; prev_we = acc_we; prev_err = e_err;
        prev_addr = acc_addr; prev_rw = acc_rw; prev_wd = acc_wd;
        gseen_a[acc_p] = 1'b1;
      end
    end
  end

  // ---------------- grant model for dut_b (fixed priority + starvation guard) ----------------
  int   bw = 0;
  logic be0, be1;

  always @(negedge clk) begin
    if (!rst_n) begin
      bw = 0;
    end else begin
      be1 = ifb.p1_req && (!ifb.p0_req || bw == MAX_WAIT);
      be0 = ifb.p0_req && !be1;
      chk("b_gnt0", 32'(ifb.p0_gnt), 32'(be0));
      chk("b_gnt1", 32'(ifb.p1_gnt), 32'(be1));
      if (be1) bw = 0;
      else if (ifb.p1_req && bw < MAX_WAIT) bw = bw + 1;
      if (ifb.p0_gnt) gseen_b[0] = 1'b1;
      if (ifb.p1_gnt) gseen_b[1] = 1'b1;
      if (bcont && (ifb.p0_gnt || ifb.p1_gnt) && bseq.size() < 12) bseq.push_back(ifb.p1_gnt);
    end
  end

  // ---------------- main sequence ----------------
  logic [31:0] saved_word;
  logic [7:0]  saved_b [0:3];

  initial begin
    for (int p = 0; p < 2; p++) begin
      pa[p] = 1'b0; wea[p] = 1'b0; addra[p] = 32'h100; wda[p] = 32'h0; rwa[p] = 3'b010;
      pb[p] = 1'b0; gseen_a[p] = 1'b0; gseen_b[p] = 1'b0;
    end
    ifb.p0_we = 1'b0; ifb.p0_addr = 32'h0; ifb.p0_rw_type = 3'b010; ifb.p0_wdata = 32'h0;
    ifb.p1_we = 1'b0; ifb.p1_addr = 32'h0; ifb.p1_rw_type = 3'b010; ifb.p1_wdata = 32'h0;
    drive();
    #1 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_p0_rsp_valid", 32'(ifa.p0_rsp_valid), 32'd0);
    chk("rst_p1_rsp_valid", 32'(ifa.p1_rsp_valid), 32'd0);
    chk("rst_p0_rsp_err", 32'(ifa.p0_rsp_err), 32'd0);
    chk("rst_p0_rdata", ifa.p0_rdata, 32'h0);
    chk("rst_p1_rdata", ifa.p1_rdata, 32'h0);
    chk("rst_mem_we", 32'(a_mem_we), 32'd0);
    chk("rst_mem_re", 32'(a_mem_re), 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_mem_wdata", a_mem_wdata, 32'h0);
    chk("rst_mem_rw", 32'(a_mem_rw_type), 32'd0);

    // Fixed-priority instance sees both ports requesting continuously from reset release.
    b_prob = 100; bcont = 1'b1;
    pb[0] = 1'b1; pb[1] = 1'b1;
    drive();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Store word then load it back in the very next cycle.
    issue(0, 1'b1, 32'h100, 3'b010, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h100, 3'b010, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    #1;
    chk("st_ld_rsp_valid", 32'(ifa.p0_rsp_valid), 32'd1);
    chk("st_ld_rdata", ifa.p0_rdata, 32'hDEAD_BEEF);

    // Misaligned half load and illegal size from port 1.
    issue(1, 1'b0, 32'h101, 3'b001, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    #1;
    chk("half_mis_valid", 32'(ifa.p1_rsp_valid), 32'd1);
    chk("half_mis_err", 32'(ifa.p1_rsp_err), 32'd1);
    chk("half_mis_rdata", ifa.p1_rdata, 32'h0);

    issue(1, 1'b0, 32'h100, 3'b011, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    #1;
    chk("ill_valid", 32'(ifa.p1_rsp_valid), 32'd1);
    chk("ill_err", 32'(ifa.p1_rsp_err), 32'd1);
    chk("ill_rdata", ifa.p1_rdata, 32'h0);

    repeat (4) next_cycle();
    bcont = 1'b0;
    b_prob = 70;
    chk("b_seq_len", 32'(bseq.size() >= 10), 32'd1);
    chk("b_seq7_port0", 32'(bseq[7]), 32'd0);
    chk("b_seq8_port1", 32'(bseq[8]), 32'd1);
    chk("b_seq9_port0", 32'(bseq[9]), 32'd0);

    // Reset asserted during the access cycle of a store.
    saved_word = mem_w[1];
    for (int i = 0; i < 4; i++) saved_b[i] = ref_b[4 + i];
    issue(0, 1'b1, 32'h104, 3'b010, 32'h55AA_55AA);
    @(posedge clk);
    #2;
    chk("rst_op_mem_we_before", 32'(a_mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_op_mem_we_drop", 32'(a_mem_we), 32'd0);
    pa[0] = 1'b0; pa[1] = 1'b0; gseen_a[0] = 1'b0; gseen_a[1] = 1'b0;
    drive();
    @(negedge clk);
    #1;
    chk("rst_op_no_rsp", 32'(ifa.p0_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ref_b[4 + i] = saved_b[i];
    chk("rst_op_mem_unchanged", mem_w[1], saved_word);
    repeat (4) next_cycle();

    // Randomized traffic on both ports of both instances.
    rand_a = 1'b1;
    repeat (3000) next_cycle();
    rand_a = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    #1;
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
